// File: rtl/dcsk_tx_scheduler.sv
// rtl/dcsk_tx_scheduler.sv - queued word scheduler driving the DCSK transmitter
// Buffers {msg, sf} words, applies seed loads from idle, paces sends with a timeout and gap.
module dcsk_tx_scheduler #(
    parameter int DEPTH    = 8,
    parameter int SEED_W   = 32,
    parameter int MIN_GAP  = 1,
    parameter int START_TO = 16,
    parameter int CNT_W    = 16,
    localparam int LVL_W   = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic              i_wr_en,
    input  logic [31:0]       i_wr_msg,
    input  logic [1:0]        i_wr_sf,
    output logic              o_full,
    output logic [LVL_W-1:0]  o_level,
    output logic              o_overflow,
    input  logic              i_seed_req,
    input  logic [SEED_W-1:0] i_seed,
    output logic [SEED_W-1:0] o_tx_seed,
    output logic              o_tx_load_seed,
    output logic              o_tx_send,
    output logic [31:0]       o_tx_msg,
    output logic [1:0]        o_tx_sf,
    input  logic              i_tx_is_sending,
    output logic              o_busy,
    output logic              o_timeout,
    output logic [CNT_W-1:0]  o_sent_cnt,
    output logic [CNT_W-1:0]  o_drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int TO_W  = (START_TO > 1) ? $clog2(START_TO) : 1;
    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(START_TO - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

    typedef enum logic [2:0] {IDLE, SEED, ISSUE, WAIT_START, WAIT_DONE, GAP} state_t;
    localparam state_t AFTER_WORD = (MIN_GAP == 0) ? IDLE : GAP;

    state_t state, state_nx;

    logic [31:0]      mem_msg [DEPTH];
    logic [1:0]       mem_sf  [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             push, pop, empty;
    logic             seed_pend;
    logic [TO_W-1:0]  wait_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             word_done;

    assign empty      = (o_level == '0);
    assign push       = i_wr_en && !o_full;
    assign o_overflow = i_wr_en && o_full;
    // Head is captured on the IDLE->ISSUE edge so msg/sf are valid alongside the send pulse.
    assign pop        = (state == IDLE) && (state_nx == ISSUE);
    assign o_busy     = (state != IDLE) || !empty;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_msg[wr_ptr] <= i_wr_msg;
            mem_sf[wr_ptr]  <= i_wr_sf;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_level <= '0;
            o_full  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                o_level <= o_level + 1'b1;
                o_full  <= (o_level == LVL_W'(DEPTH - 1));
            end else if (pop && !push) begin
                o_level <= o_level - 1'b1;
                o_full  <= 1'b0;
            end
        end
    end

    // A request landing in the SEED cycle keeps the flag set so the newer seed is loaded too.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_tx_seed <= '0;
            seed_pend <= 1'b0;
        end else if (i_seed_req) begin
            o_tx_seed <= i_seed;
            seed_pend <= 1'b1;
        end else if (state == SEED) begin
            seed_pend <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) state <= IDLE;
        else           state <= state_nx;
    end

    // Entering SEED waits out a same-cycle request so o_tx_seed is settled before the load.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (seed_pend || i_seed_req) begin
                    if (!i_seed_req) state_nx = SEED;
                end else if (!empty) begin
                    state_nx = ISSUE;
                end
            end
            SEED:       state_nx = IDLE;
            ISSUE:      state_nx = WAIT_START;
            WAIT_START: begin
                if (i_tx_is_sending)          state_nx = WAIT_DONE;
                else if (wait_cnt == TO_LAST) state_nx = AFTER_WORD;
            end
            WAIT_DONE:  if (!i_tx_is_sending) state_nx = AFTER_WORD;
            GAP:        if (gap_cnt == GAP_LAST) state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_tx_load_seed = 1'b0;
        o_tx_send      = 1'b0;
        o_timeout      = 1'b0;
        word_done      = 1'b0;
        case (state)
            SEED:       o_tx_load_seed = 1'b1;
            ISSUE:      o_tx_send      = 1'b1;
            WAIT_START: o_timeout      = !i_tx_is_sending && (wait_cnt == TO_LAST);
            WAIT_DONE:  word_done      = !i_tx_is_sending;
            default:    ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_tx_msg   <= '0;
            o_tx_sf    <= '0;
            wait_cnt   <= '0;
            gap_cnt    <= '0;
            o_sent_cnt <= '0;
            o_drop_cnt <= '0;
        end else begin
            if (pop) begin
                o_tx_msg <= mem_msg[rd_ptr];
                o_tx_sf  <= mem_sf[rd_ptr];
            end
            wait_cnt <= (state == WAIT_START) ? wait_cnt + 1'b1 : '0;
            gap_cnt  <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            if (word_done) o_sent_cnt <= o_sent_cnt + 1'b1;
            if (o_timeout) o_drop_cnt <= o_drop_cnt + 1'b1;
        end
    end

endmodule
